// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sample width and FFT length, ctr width,
// and width-parameterised saturate / round-half-up helpers.
package fft_pkg;

    localparam int unsigned FFT_WIDTH = 25;
    localparam int unsigned FFT_N     = 1024;

    typedef logic signed [63:0] wide_t;

    localparam wide_t WIDE_ONE = 64'sd1;

    function automatic int unsigned ctr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Clamp v into the signed range of a w-bit word.
    function automatic wide_t sat(input wide_t v, input int unsigned w);
        wide_t hi;
        wide_t lo;
        hi = (WIDE_ONE <<< (w - 1)) - WIDE_ONE;
        lo = -(WIDE_ONE <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic wide_t round_half_up(input wide_t v, input int unsigned w);
        return sat((v + WIDE_ONE) >>> 1, w);
    endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Feedback delay line for one SDF stage: DEPTH x DW words, read-before-write on
// a shared address, so a word written at address a returns DEPTH cycles later.
module fft_delay_line
    import fft_pkg::*;
#(
    parameter  int unsigned DW    = 2 * FFT_WIDTH,
    parameter  int unsigned DEPTH = 512,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [1 << AW];

    always_ff @(posedge clk) begin
        mem[addr_i] <= wdata_i;
    end

    generate
        if (DEPTH >= 32) begin : g_bram
            // Synchronous read one address ahead: the address advances by one every
            // cycle, so the registered word lines up with addr_i on the next cycle.
            logic [AW-1:0] addr_nxt;
            logic [DW-1:0] rd_q;

            assign addr_nxt = addr_i + AW'(1);

            always_ff @(posedge clk) begin
                rd_q <= mem[addr_nxt];
            end

            assign rdata_o = rd_q;
        end else begin : g_reg
            assign rdata_o = mem[addr_i];
        end
    endgenerate

endmodule

// File: rtl/fft_bf.sv
// Radix-2 DIF single-delay-feedback butterfly stage with aligned ctr/carry side-band.
// Define FFT_BF_SCALE_EN to halve sums/differences (round-half-up); otherwise they saturate.
module fft_bf
    import fft_pkg::*;
#(
    parameter  int unsigned WIDTH = FFT_WIDTH,
    parameter  int unsigned N     = FFT_N,
    parameter  int unsigned DELAY = 512,
    localparam int unsigned CW    = ctr_width(N)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    carry_in,
    output logic                    carry_out,
    input  logic [CW-1:0]           ctr_i,
    output logic [CW-1:0]           ctr_o,
    input  logic signed [WIDTH-1:0] x_re_i,
    input  logic signed [WIDTH-1:0] x_im_i,
    output logic signed [WIDTH-1:0] z_re_o,
    output logic signed [WIDTH-1:0] z_im_o
);

    localparam int unsigned AW = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam int unsigned PB = $clog2(DELAY);
    localparam int unsigned KW = $clog2(DELAY + 1);

    logic                    ph;
    logic [AW-1:0]           addr;
    logic [2*WIDTH-1:0]      wdata;
    logic [2*WIDTH-1:0]      rdata;
    logic signed [WIDTH-1:0] d_re, d_im;
    logic signed [WIDTH:0]   s_re, s_im, t_re, t_im;
    logic signed [WIDTH-1:0] z_re_d, z_re_q, z_im_d, z_im_q;
    logic [CW-1:0]           ctr_d, ctr_q;
    logic [KW-1:0]           cnt_d, cnt_q;
    logic                    carry_d, carry_q;

    function automatic logic signed [WIDTH-1:0] reduce(input logic signed [WIDTH:0] v);
`ifdef FFT_BF_SCALE_EN
        return WIDTH'(round_half_up(wide_t'(v), WIDTH));
`else
        return WIDTH'(sat(wide_t'(v), WIDTH));
`endif
    endfunction

    fft_delay_line #(
        .DW    (2 * WIDTH),
        .DEPTH (DELAY)
    ) u_dline (
        .clk     (clk),
        .addr_i  (addr),
        .wdata_i (wdata),
        .rdata_o (rdata)
    );

    always_comb begin
        addr = '0;
        if (DELAY > 1) addr = ctr_i[AW-1:0];
        ph           = ctr_i[PB];
        {d_re, d_im} = rdata;

        s_re = {d_re[WIDTH-1], d_re} + {x_re_i[WIDTH-1], x_re_i};
        s_im = {d_im[WIDTH-1], d_im} + {x_im_i[WIDTH-1], x_im_i};
        t_re = {d_re[WIDTH-1], d_re} - {x_re_i[WIDTH-1], x_re_i};
        t_im = {d_im[WIDTH-1], d_im} - {x_im_i[WIDTH-1], x_im_i};

        // Fill half stores the input and drains the previous differences;
        // butterfly half emits sums and parks differences for the next half.
        wdata  = {x_re_i, x_im_i};
        z_re_d = d_re;
        z_im_d = d_im;
        if (ph) begin
            wdata  = {reduce(t_re), reduce(t_im)};
            z_re_d = reduce(s_re);
            z_im_d = reduce(s_im);
        end

        ctr_d = ctr_i - CW'(DELAY);

        cnt_d = cnt_q;
        if (carry_in && (cnt_q != KW'(DELAY))) cnt_d = cnt_q + KW'(1);
        carry_d = carry_q | (ph && (cnt_q == KW'(DELAY)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_re_q  <= '0;
            z_im_q  <= '0;
            ctr_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            z_re_q  <= z_re_d;
            z_im_q  <= z_im_d;
            ctr_q   <= ctr_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
        end
    end

    assign z_re_o    = z_re_q;
    assign z_im_o    = z_im_q;
    assign ctr_o     = ctr_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_fft_bf.sv
// Directed bench for fft_bf: small stage (WIDTH=8, N=8, DELAY=4) plus a random
// stream on a full-size stage (WIDTH=25, N=1024, DELAY=512) against a frame model.
module tb_fft_bf;

    localparam int NFR = 20;

`ifdef FFT_BF_SCALE_EN
    localparam int IMP   = 32;
    localparam int CS_RE = 10;
    localparam int CS_IM = -3;
    localparam int SAT_P = 100;
    localparam int SAT_N = -100;
`else
    localparam int IMP   = 64;
    localparam int CS_RE = 20;
    localparam int CS_IM = -6;
    localparam int SAT_P = 127;
    localparam int SAT_N = -128;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic              cin_s, co_s;
    logic [2:0]        ctr_s, ctro_s;
    logic signed [7:0] xr_s, xi_s, zr_s, zi_s;

    logic               cin_b, co_b;
    logic [9:0]         ctr_b, ctro_b;
    logic signed [24:0] xr_b, xi_b, zr_b, zi_b;

    int n_chk  = 0;
    int n_fail = 0;

    logic              e_co;
    logic [2:0]        e_ctr;
    logic signed [7:0] e_re, e_im;

    fft_bf #(.WIDTH(8), .N(8), .DELAY(4)) u_small (
        .clk       (clk),
        .rst_n     (rst_n),
        .carry_in  (cin_s),
        .carry_out (co_s),
        .ctr_i     (ctr_s),
        .ctr_o     (ctro_s),
        .x_re_i    (xr_s),
        .x_im_i    (xi_s),
        .z_re_o    (zr_s),
        .z_im_o    (zi_s)
    );

    fft_bf #(.WIDTH(25), .N(1024), .DELAY(512)) u_big (
        .clk       (clk),
        .rst_n     (rst_n),
        .carry_in  (cin_b),
        .carry_out (co_b),
        .ctr_i     (ctr_b),
        .ctr_o     (ctro_b),
        .x_re_i    (xr_b),
        .x_im_i    (xi_b),
        .z_re_o    (zr_b),
        .z_im_o    (zi_b)
    );

    function automatic int red_b(input int v);
`ifdef FFT_BF_SCALE_EN
        return (v + 1) >>> 1;
`else
        if (v > 16777215) return 16777215;
        if (v < -16777216) return -16777216;
        return v;
`endif
    endfunction

    task automatic cyc_s(input int re, input int im, input logic cin);
        xr_s  = 8'(re);
        xi_s  = 8'(im);
        cin_s = cin;
        @(posedge clk);
        #1;
        ctr_s = ctr_s + 3'd1;
    endtask

    task automatic cyc_b(input int re, input int im);
        xr_b  = 25'(re);
        xi_b  = 25'(im);
        cin_b = 1'b1;
        @(posedge clk);
        #1;
        ctr_b = ctr_b + 10'd1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cin_s = 1'b0; ctr_s = '0; xr_s = '0; xi_s = '0;
        cin_b = 1'b0; ctr_b = '0; xr_b = '0; xi_b = '0;
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cin_s = 1'b0; ctr_s = '0; xr_s = '0; xi_s = '0;
        cin_b = 1'b0; ctr_b = '0; xr_b = '0; xi_b = '0;
        #1;
        n_chk++;
        if ({co_s, ctro_s, zr_s, zi_s} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_small: got co=%0b ctr=%0d z=(%0d,%0d) want all 0", co_s, ctro_s, zr_s, zi_s);
        end
        n_chk++;
        if ({co_b, ctro_b, zr_b, zi_b} !== 61'd0) begin
            n_fail++;
            $display("FAIL reset_big: got co=%0b ctr=%0d z=(%0d,%0d) want all 0", co_b, ctro_b, zr_b, zi_b);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_impulse();
        do_reset();
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 8; k++) begin
                cyc_s((f == 0 && k == 0) ? 64 : 0, 0, 1'b1);
                if (f == 1 && k >= 4) continue;
                e_co  = (f == 1 || k >= 4);
                e_ctr = 3'((f == 0) ? k - 4 : k + 4);
                e_re  = 8'((((f == 0) ? k - 4 : k) == 0) ? IMP : 0);
                e_im  = 8'd0;
                if (f == 0 && k < 4) begin
                    n_chk++;
                    if (co_s !== 1'b0) begin
                        n_fail++;
                        $display("FAIL impulse_fill_carry[%0d]: got %0b want 0", k, co_s);
                    end
                end else begin
                    n_chk++;
                    if ({co_s, ctro_s, zr_s, zi_s} !== {e_co, e_ctr, e_re, e_im}) begin
                        n_fail++;
                        $display("FAIL impulse[%0d.%0d]: got co=%0b ctr=%0d z=(%0d,%0d) want co=%0b ctr=%0d z=(%0d,%0d)",
                                 f, k, co_s, ctro_s, zr_s, zi_s, e_co, e_ctr, e_re, e_im);
                    end
                end
            end
        end
    endtask

    task automatic test_constant();
        do_reset();
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 8; k++) begin
                cyc_s(10, -3, 1'b1);
                if (f == 0 && k < 4) begin
                    n_chk++;
                    if (co_s !== 1'b0) begin
                        n_fail++;
                        $display("FAIL const_carry_early[%0d]: got %0b want 0", k, co_s);
                    end
                end else begin
                    e_ctr = 3'(k - 4);
                    e_re  = (k >= 4) ? 8'(CS_RE) : 8'd0;
                    e_im  = (k >= 4) ? 8'(CS_IM) : 8'd0;
                    n_chk++;
                    if ({co_s, ctro_s, zr_s, zi_s} !== {1'b1, e_ctr, e_re, e_im}) begin
                        n_fail++;
                        $display("FAIL const[%0d.%0d]: got co=%0b ctr=%0d z=(%0d,%0d) want co=1 ctr=%0d z=(%0d,%0d)",
                                 f, k, co_s, ctro_s, zr_s, zi_s, e_ctr, e_re, e_im);
                    end
                end
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 8; k++) begin
                if (f == 0)      cyc_s(100, -100, 1'b1);
                else if (f == 1) cyc_s(-100, 100, 1'b1);
                else             cyc_s(0, 0, 1'b1);
                if ((f == 0 && k < 4) || (f == 2 && k >= 4)) continue;
                e_ctr = 3'(k - 4);
                e_re  = 8'd0;
                e_im  = 8'd0;
                if (k >= 4) begin
                    e_re = (f == 0) ? 8'(SAT_P) : 8'(SAT_N);
                    e_im = (f == 0) ? 8'(SAT_N) : 8'(SAT_P);
                end
                n_chk++;
                if ({co_s, ctro_s, zr_s, zi_s} !== {1'b1, e_ctr, e_re, e_im}) begin
                    n_fail++;
                    $display("FAIL saturate[%0d.%0d]: got co=%0b ctr=%0d z=(%0d,%0d) want co=1 ctr=%0d z=(%0d,%0d)",
                             f, k, co_s, ctro_s, zr_s, zi_s, e_ctr, e_re, e_im);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        for (int k = 0; k < 6; k++) cyc_s(10, -3, 1'b1);
        n_chk++;
        if ({co_s, ctro_s, zr_s, zi_s} !== {1'b1, 3'd1, 8'(CS_RE), 8'(CS_IM)}) begin
            n_fail++;
            $display("FAIL midreset_pre: got co=%0b ctr=%0d z=(%0d,%0d) want co=1 ctr=1 z=(%0d,%0d)",
                     co_s, ctro_s, zr_s, zi_s, CS_RE, CS_IM);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({co_s, ctro_s, zr_s, zi_s} !== 20'd0) begin
            n_fail++;
            $display("FAIL midreset_async: got co=%0b ctr=%0d z=(%0d,%0d) want all 0", co_s, ctro_s, zr_s, zi_s);
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            ctr_s = ctr_s + 3'd1;
        end
        n_chk++;
        if ({co_s, ctro_s, zr_s, zi_s} !== 20'd0) begin
            n_fail++;
            $display("FAIL midreset_held: got co=%0b ctr=%0d z=(%0d,%0d) want all 0", co_s, ctro_s, zr_s, zi_s);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc_s(10, -3, 1'b1);
            n_chk++;
            if (k < 4) begin
                if (co_s !== 1'b0) begin
                    n_fail++;
                    $display("FAIL midreset_carry_low[%0d]: got %0b want 0", k, co_s);
                end
            end else if ({co_s, ctro_s, zr_s, zi_s} !== {1'b1, 3'd0, 8'(CS_RE), 8'(CS_IM)}) begin
                n_fail++;
                $display("FAIL midreset_recover: got co=%0b ctr=%0d z=(%0d,%0d) want co=1 ctr=0 z=(%0d,%0d)",
                         co_s, ctro_s, zr_s, zi_s, CS_RE, CS_IM);
            end
        end
    endtask

    task automatic test_carry_gap();
        logic [7:0] pat;
        pat = 8'b1111_0011;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            cyc_s(10, -3, pat[k]);
            e_co = (k >= 6);
            n_chk++;
            if (co_s !== e_co) begin
                n_fail++;
                $display("FAIL gap_carry[%0d]: got %0b want %0b", k, co_s, e_co);
            end
        end
        n_chk++;
        if ({ctro_s, zr_s, zi_s} !== {3'd3, 8'(CS_RE), 8'(CS_IM)}) begin
            n_fail++;
            $display("FAIL gap_data: got ctr=%0d z=(%0d,%0d) want ctr=3 z=(%0d,%0d)", ctro_s, zr_s, zi_s, CS_RE, CS_IM);
        end
    endtask

    task automatic test_random_stream();
        int a_re[512], a_im[512], pd_re[512], pd_im[512];
        int b_re, b_im, er, ei;
        logic signed [24:0] r;
        do_reset();
        for (int f = 0; f <= NFR; f++) begin
            for (int j = 0; j < 512; j++) begin
                r = 25'($urandom); a_re[j] = int'(r);
                r = 25'($urandom); a_im[j] = int'(r);
                cyc_b(a_re[j], a_im[j]);
                n_chk++;
                if (f == 0) begin
                    if (co_b !== 1'b0) begin
                        n_fail++;
                        $display("FAIL rand_fill_carry[%0d]: got %0b want 0", j, co_b);
                    end
                end else if ({co_b, ctro_b, zr_b, zi_b} !== {1'b1, 10'(512 + j), 25'(pd_re[j]), 25'(pd_im[j])}) begin
                    n_fail++;
                    $display("FAIL rand_diff[%0d.%0d]: got co=%0b ctr=%0d z=(%0d,%0d) want co=1 ctr=%0d z=(%0d,%0d)",
                             f, j, co_b, ctro_b, zr_b, zi_b, 512 + j, pd_re[j], pd_im[j]);
                end
            end
            if (f == NFR) break;
            for (int j = 0; j < 512; j++) begin
                r = 25'($urandom); b_re = int'(r);
                r = 25'($urandom); b_im = int'(r);
                cyc_b(b_re, b_im);
                er       = red_b(a_re[j] + b_re);
                ei       = red_b(a_im[j] + b_im);
                pd_re[j] = red_b(a_re[j] - b_re);
                pd_im[j] = red_b(a_im[j] - b_im);
                n_chk++;
                if ({co_b, ctro_b, zr_b, zi_b} !== {1'b1, 10'(j), 25'(er), 25'(ei)}) begin
                    n_fail++;
                    $display("FAIL rand_sum[%0d.%0d]: got co=%0b ctr=%0d z=(%0d,%0d) want co=1 ctr=%0d z=(%0d,%0d)",
                             f, j, co_b, ctro_b, zr_b, zi_b, j, er, ei);
                end
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_impulse();
        test_constant();
        test_saturation();
        test_reset_midframe();
        test_carry_gap();
        test_random_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
